id_stage: RTL and testbench
===========================

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: BYPASS, 1, enables same-cycle writeback-to-operand forwarding (0 = plain register-file read).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  fetch presents an instruction.
REQ-005 in_ready  output  1  stage accepts the instruction this cycle.
REQ-006 in_instr  input  32  raw RV32I instruction word.
REQ-007 in_pc  input  32  PC of in_instr.
REQ-008 flush  input  1  discard held and incoming instruction.
REQ-009 rs1_addr  output  5  register-file read port 1 address.
REQ-010 rs2_addr  output  5  register-file read port 2 address.
REQ-011 rs1_data  input  32  register-file read data 1 (combinational read).
REQ-012 rs2_data  input  32  register-file read data 2 (combinational read).
REQ-013 wb_we, wb_addr, wb_data  input  1/5/32  writeback port, same signals driving the register-file write port.
REQ-014 out_valid  output  1  decoded entry held for execute.
REQ-015 out_ready  input  1  execute consumes the entry.
REQ-016 out_pc, out_rs1_val, out_rs2_val, out_imm  output  32 each  decoded PC, operands, sign-extended immediate.
REQ-017 out_rd  output  5; out_rd_we  output  1; out_opcode  output  7; out_funct3  output  3; out_funct7b5  output  1; out_illegal  output  1.

Function
REQ-018 rs1_addr = in_instr[19:15], rs2_addr = in_instr[24:20], combinationally, regardless of in_valid.
REQ-019 in_ready = !out_valid || out_ready; accept = in_valid && in_ready.
REQ-020 On accept without flush, all out_* register the decoded instruction; latency in_instr -> out_valid exactly 1 cycle.
REQ-021 Operand capture: index 0 -> 0; else if BYPASS && wb_we && wb_addr == index -> wb_data; else rsX_data.
REQ-022 While out_valid && !out_ready, all out_* hold, except out_rs1_val/out_rs2_val update to wb_data when wb_we && wb_addr == held source index != 0.
REQ-023 out_valid && out_ready without a new accept -> out_valid clears next cycle; with accept -> new entry loads, back-to-back, no bubble.
REQ-024 Immediates: I (LOAD, OP-IMM, JALR), S, B, U (LUI, AUIPC), J per RV32I, sign bit instr[31]; R-type, FENCE, SYSTEM -> 0.
REQ-025 out_rd_we = 0 for STORE, BRANCH, FENCE, SYSTEM, illegal, or rd == 0; else 1.
REQ-026 out_illegal = 1 when opcode not one of the eleven RV32I opcodes or instr[1:0] != 2'b11; entry still passes with out_rd_we = 0.
REQ-027 flush: out_valid = 0 next cycle; a same-cycle accept is dropped; flush priority over accept and hold.
REQ-028 Data outputs when out_valid = 0 are don't-care except after reset.

Reset
REQ-029 rst high at a clock edge: out_valid = 0, all other out_* = 0 next cycle; in_ready = 1 after reset.
REQ-030 rst mid-stall discards the held entry; no accept occurs on a cycle with rst asserted.

Structure
REQ-031 Opcode constants (OP_LUI ... OP_SYSTEM) and immediate-type encodings live in shared package rv32i_pkg, also used by execute.
REQ-032 Immediate generation is sub-module imm_gen (purely combinational: instr in, imm out); id_stage owns handshake, capture and forwarding state.

Verification
REQ-033 Reg x1 = 0xA5A5A5A5, accept ADDI x2,x1,-1 (0xFFF08113) -> next cycle out_valid=1, out_rs1_val=0xA5A5A5A5, out_imm=0xFFFFFFFF, out_rd=2, out_rd_we=1.
REQ-034 Same cycle as accept of ADD x3,x1,x1, wb_we=1 wb_addr=1 wb_data=0x12345678 -> out_rs1_val=out_rs2_val=0x12345678.
REQ-035 Hold out_ready=0 3 cycles after accepting ADD x3,x4,x5, wb writes x5=0xDEADBEEF in cycle 2 -> out_rs2_val=0xDEADBEEF, other fields unchanged, in_ready=0 throughout.
REQ-036 SW x5,8(x6) (0x00532423) -> out_imm=8, out_rd_we=0; BEQ with offset -4 -> out_imm=0xFFFFFFFC; instr 0x00000000 -> out_illegal=1, out_rd_we=0.
REQ-037 flush with in_valid=1 and out_valid=1 -> out_valid=0 next cycle; in_ready=1 following cycle.
REQ-038 rst during stall -> out_valid=0 and all out_* = 0 next cycle; wb writes to x0 never forward a nonzero operand.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: base opcodes, immediate formats and the
// decoded-entry layout handed from decode to execute.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;
  } id_entry_t;

  function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
    imm_type_e t;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR: t = IMM_I;
      OP_STORE:                 t = IMM_S;
      OP_BRANCH:                t = IMM_B;
      OP_LUI, OP_AUIPC:         t = IMM_U;
      OP_JAL:                   t = IMM_J;
      default:                  t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic is_legal(input logic [6:0] opcode);
    logic ok;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_OP, OP_FENCE, OP_SYSTEM: ok = 1'b1;
      default:                                      ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    logic w;
    case (opcode)
      OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM: w = 1'b0;
      default:                                  w = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch handshake, register-file read/writeback ports and
// the decoded entry offered to execute.
interface id_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_val;
  logic [31:0] out_rs2_val;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, flush, rs1_data, rs2_data,
           wb_we, wb_addr, wb_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_rs1_val,
           out_rs2_val, out_imm, out_rd, out_rd_we, out_opcode, out_funct3,
           out_funct7b5, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, rs1_data, rs2_data,
           wb_we, wb_addr, wb_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_rs1_val,
           out_rs2_val, out_imm, out_rd, out_rd_we, out_opcode, out_funct3,
           out_funct7b5, out_illegal
  );
endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; formats without an immediate
// (R-type, FENCE, SYSTEM, unknown opcodes) yield zero.
module imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (imm_type_of(instr[6:0]))
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// Decode stage: single-entry skid between fetch and execute with operand
// capture, writeback forwarding at capture time and while the entry stalls.
module id_stage
  import rv32i_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic rst,
  id_stage_if.slave bus
);

  logic                 valid_q, valid_d;
  id_entry_t            entry_q, entry_d, dec_entry;
  logic [1:0][31:0]     op_val_q, op_val_d, cap_val, held_val, rf_data;
  logic [1:0][4:0]      src_idx_q, src_idx_d, src_idx;
  logic [31:0]          dec_imm;
  logic                 accept;

  assign src_idx      = {bus.in_instr[24:20], bus.in_instr[19:15]};
  assign rf_data      = {bus.rs2_data, bus.rs1_data};
  assign bus.rs1_addr = src_idx[0];
  assign bus.rs2_addr = src_idx[1];
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  imm_gen u_imm_gen (
    .instr (bus.in_instr),
    .imm   (dec_imm)
  );

  // Index 0 of the pair is rs1, index 1 is rs2.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      assign cap_val[gi] =
          (src_idx[gi] == 5'd0) ? 32'd0 :
          (BYPASS && bus.wb_we && bus.wb_addr == src_idx[gi]) ? bus.wb_data :
          rf_data[gi];
      // A stalled entry must still see writes retiring behind it.
      assign held_val[gi] =
          (bus.wb_we && src_idx_q[gi] != 5'd0 && bus.wb_addr == src_idx_q[gi]) ?
          bus.wb_data : op_val_q[gi];
    end
  endgenerate

  always_comb begin
    dec_entry          = '0;
    dec_entry.pc       = bus.in_pc;
    dec_entry.imm      = dec_imm;
    dec_entry.rd       = bus.in_instr[11:7];
    dec_entry.opcode   = bus.in_instr[6:0];
    dec_entry.funct3   = bus.in_instr[14:12];
    dec_entry.funct7b5 = bus.in_instr[30];
    dec_entry.illegal  = !is_legal(bus.in_instr[6:0]) || (bus.in_instr[1:0] != 2'b11);
    dec_entry.rd_we    = !dec_entry.illegal && writes_rd(bus.in_instr[6:0]) &&
                         (bus.in_instr[11:7] != 5'd0);
  end

  always_comb begin
    valid_d   = valid_q;
    entry_d   = entry_q;
    op_val_d  = op_val_q;
    src_idx_d = src_idx_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d   = 1'b1;
      entry_d   = dec_entry;
      op_val_d  = cap_val;
      src_idx_d = src_idx;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      op_val_d = held_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      entry_q   <= '0;
      op_val_q  <= '0;
      src_idx_q <= '0;
    end else begin
      valid_q   <= valid_d;
      entry_q   <= entry_d;
      op_val_q  <= op_val_d;
      src_idx_q <= src_idx_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = entry_q.pc;
  assign bus.out_rs1_val  = op_val_q[0];
  assign bus.out_rs2_val  = op_val_q[1];
  assign bus.out_imm      = entry_q.imm;
  assign bus.out_rd       = entry_q.rd;
  assign bus.out_rd_we    = entry_q.rd_we;
  assign bus.out_opcode   = entry_q.opcode;
  assign bus.out_funct3   = entry_q.funct3;
  assign bus.out_funct7b5 = entry_q.funct7b5;
  assign bus.out_illegal  = entry_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions push expected entries,
// a negedge monitor pops and compares whenever execute consumes an entry.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        illegal;
  } exp_t;

  logic clk;
  logic rst;
  logic [31:0] regs [32];
  exp_t  exp_q [$];
  string name_q [$];
  int n_vec = 0;
  int n_err = 0;

  id_stage_if bus ();

  id_stage #(.BYPASS(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model; x0 deliberately holds garbage so the stage must zero it.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
      regs[0]  <= 32'hBAD0BAD0;
      regs[1]  <= 32'hA5A5A5A5;
      regs[3]  <= 32'h33333333;
      regs[4]  <= 32'h00000011;
      regs[5]  <= 32'h00000022;
      regs[6]  <= 32'h00001000;
      regs[8]  <= 32'h88888888;
      regs[31] <= 32'h31313131;
    end else if (bus.wb_we) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end
  assign bus.rs1_data = regs[bus.rs1_addr];
  assign bus.rs2_data = regs[bus.rs2_addr];

  function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [4:0] rd, input logic we,
                              input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic ill);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.rd = rd; e.rd_we = we;
    e.opcode = op; e.funct3 = f3; e.funct7b5 = f7; e.illegal = ill;
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("pc=%h rs1=%h rs2=%h imm=%h rd=%0d we=%b op=%h f3=%0d f7b5=%b ill=%b",
                     e.pc, e.rs1, e.rs2, e.imm, e.rd, e.rd_we, e.opcode, e.funct3,
                     e.funct7b5, e.illegal);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] need);
    n_vec++;
    if (got !== need) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", nm, got, need);
    end else begin
      $display("chk %s ok (%h)", nm, got);
    end
  endtask

  // Monitor: one scoreboard comparison per consumed entry.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t got;
      got = mk(bus.out_pc, bus.out_rs1_val, bus.out_rs2_val, bus.out_imm, bus.out_rd,
               bus.out_rd_we, bus.out_opcode, bus.out_funct3, bus.out_funct7b5,
               bus.out_illegal);
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_entry: got %s, need no entry", fmt(got));
      end else begin
        exp_t e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL %s: got %s, need %s", nm, fmt(got), fmt(e));
        end else begin
          $display("txn %s ok: %s", nm, fmt(got));
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one instruction (with optional writeback in the same cycle) until accepted.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic wbe, input logic [4:0] wba, input logic [31:0] wbd,
                      input bit push, input exp_t e, input string nm);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    bus.in_pc    = pc;
    bus.wb_we    = wbe;
    bus.wb_addr  = wba;
    bus.wb_data  = wbd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_accept: got in_ready=0 for 20 cycles, need acceptance", nm);
    end else if (push) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.wb_we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, need finish within 100000 time units");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] I_ADDI  = 32'hFFF08113; // addi x2,x1,-1
  localparam logic [31:0] I_ADD11 = 32'h001081B3; // add  x3,x1,x1
  localparam logic [31:0] I_ADD00 = 32'h000003B3; // add  x7,x0,x0
  localparam logic [31:0] I_JAL   = 32'h001000EF; // jal  x1,+2048
  localparam logic [31:0] I_ADD45 = 32'h005201B3; // add  x3,x4,x5
  localparam logic [31:0] I_LUI   = 32'h123454B7; // lui  x9,0x12345
  localparam logic [31:0] I_SW    = 32'h00532423; // sw   x5,8(x6)
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3; // beq  x0,x0,-4
  localparam exp_t NO_EXP = '0;

  initial begin
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 32'h0;
    bus.in_pc     = 32'h0;
    bus.flush     = 1'b0;
    bus.wb_we     = 1'b0;
    bus.wb_addr   = 5'd0;
    bus.wb_data   = 32'h0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_pc", bus.out_pc, 32'd0);
    chk("reset_out_imm", bus.out_imm, 32'd0);

    // Source addresses follow in_instr even without in_valid.
    bus.in_instr = I_ADD45;
    #1;
    chk("rs1_addr_comb", 32'(bus.rs1_addr), 32'd4);
    chk("rs2_addr_comb", 32'(bus.rs2_addr), 32'd5);
    bus.in_instr = 32'h0;
    idle(1);

    // Back-to-back stream with out_ready held high.
    send(I_ADDI, 32'h100, 1'b0, 5'd0, 32'h0, 1'b1,
         mk(32'h100, 32'hA5A5A5A5, 32'h31313131, 32'hFFFFFFFF, 5'd2, 1'b1,
            7'h13, 3'd0, 1'b1, 1'b0), "addi_basic");
    send(I_ADD11, 32'h104, 1'b1, 5'd1, 32'h12345678, 1'b1,
         mk(32'h104, 32'h12345678, 32'h12345678, 32'h0, 5'd3, 1'b1,
            7'h33, 3'd0, 1'b0, 1'b0), "add_bypass");
    send(I_ADD00, 32'h108, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1,
         mk(32'h108, 32'h0, 32'h0, 32'h0, 5'd7, 1'b1,
            7'h33, 3'd0, 1'b0, 1'b0), "add_x0_no_fwd");
    send(I_JAL, 32'h10C, 1'b0, 5'd0, 32'h0, 1'b1,
         mk(32'h10C, 32'h0, 32'h12345678, 32'h00000800, 5'd1, 1'b1,
            7'h6F, 3'd0, 1'b0, 1'b0), "jal_imm");
    idle(1);

    // Stall for three cycles with a writeback to the held rs2 in the second.
    bus.out_ready = 1'b0;
    send(I_ADD45, 32'h110, 1'b0, 5'd0, 32'h0, 1'b1,
         mk(32'h110, 32'h00000011, 32'hDEADBEEF, 32'h0, 5'd3, 1'b1,
            7'h33, 3'd0, 1'b0, 1'b0), "add_stall_fwd");
    bus.in_valid = 1'b1;
    bus.in_instr = I_LUI;
    bus.in_pc    = 32'h114;
    @(negedge clk);
    chk("stall_in_ready_c1", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.wb_we   = 1'b1;
    bus.wb_addr = 5'd5;
    bus.wb_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("stall_in_ready_c2", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.wb_we = 1'b0;
    @(negedge clk);
    chk("stall_in_ready_c3", 32'(bus.in_ready), 32'd0);
    chk("stall_rs2_updated", bus.out_rs2_val, 32'hDEADBEEF);
    chk("stall_rs1_held", bus.out_rs1_val, 32'h00000011);
    chk("stall_pc_held", bus.out_pc, 32'h110);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    // The waiting LUI is taken on the same cycle the stalled entry drains.
    send(I_LUI, 32'h114, 1'b0, 5'd0, 32'h0, 1'b1,
         mk(32'h114, 32'h88888888, 32'h33333333, 32'h12345000, 5'd9, 1'b1,
            7'h37, 3'd5, 1'b0, 1'b0), "lui_after_stall");

    send(I_SW, 32'h118, 1'b0, 5'd0, 32'h0, 1'b1,
         mk(32'h118, 32'h00001000, 32'hDEADBEEF, 32'h00000008, 5'd8, 1'b0,
            7'h23, 3'd2, 1'b0, 1'b0), "sw_imm");
    send(I_BEQ, 32'h11C, 1'b0, 5'd0, 32'h0, 1'b1,
         mk(32'h11C, 32'h0, 32'h0, 32'hFFFFFFFC, 5'd29, 1'b0,
            7'h63, 3'd0, 1'b1, 1'b0), "beq_neg4");
    send(32'h00000000, 32'h120, 1'b0, 5'd0, 32'h0, 1'b1,
         mk(32'h120, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0,
            7'h00, 3'd0, 1'b0, 1'b1), "zero_illegal");
    idle(1);

    // Flush with a held entry and an incoming instruction: both discarded.
    bus.out_ready = 1'b0;
    send(I_ADDI, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, NO_EXP, "flush_setup");
    bus.in_valid = 1'b1;
    bus.in_instr = I_ADD11;
    bus.in_pc    = 32'h204;
    bus.flush    = 1'b1;
    @(negedge clk);
    chk("flush_pre_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    idle(2);

    // Reset while stalled, with an instruction offered in the reset cycle.
    bus.out_ready = 1'b0;
    send(I_ADD45, 32'h300, 1'b0, 5'd0, 32'h0, 1'b0, NO_EXP, "rst_setup");
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_instr = I_LUI;
    bus.in_pc    = 32'h304;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_stall_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_stall_out_pc", bus.out_pc, 32'd0);
    chk("rst_stall_rs1", bus.out_rs1_val, 32'd0);
    chk("rst_stall_rs2", bus.out_rs2_val, 32'd0);
    chk("rst_stall_imm", bus.out_imm, 32'd0);
    chk("rst_stall_fields",
        32'({bus.out_rd, bus.out_rd_we, bus.out_opcode, bus.out_funct3,
             bus.out_funct7b5, bus.out_illegal}), 32'd0);
    chk("rst_stall_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    idle(3);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
